// File: rtl/kb_event_decoder.sv
// PS/2 scan-byte decoder: make/break/extended key events into a first-word-fall-through FIFO,
// with an optional typematic-repeat filter and a sticky overflow flag.
module kb_event_decoder #(
    parameter int unsigned W_SIZE        = 2,
    parameter bit          REPORT_MAKE   = 1'b1,
    parameter bit          FILTER_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_data,
    input  logic       scan_done_tick,
    input  logic       rd_key_event,
    input  logic       clr_overflow,
    output logic [9:0] key_event,
    output logic       kb_buf_empty,
    output logic       kb_buf_full,
    output logic       overflow
);

    localparam int unsigned Depth = 2 ** W_SIZE;
    localparam logic [W_SIZE:0] CountFull = (W_SIZE + 1)'(Depth);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e            state_q, state_d;
    logic              held_valid_q, held_valid_d;
    logic [8:0]        held_q, held_d;
    logic [W_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [W_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [W_SIZE:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [9:0]        mem_q [Depth];

    logic       emit, ev_brk, ev_ext, held_hit, wr_en, do_push, do_pop, drop;
    logic [8:0] ev_key;

    // Byte decoder
    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        ev_brk  = 1'b0;
        ev_ext  = 1'b0;
        if (scan_done_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (scan_data == 8'hE0) begin
                        state_d = StExt;
                    end else if (scan_data == 8'hF0) begin
                        state_d = StBrk;
                    end else if (!(scan_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
                        emit = 1'b1;
                    end
                end
                StExt: begin
                    if (scan_data == 8'hF0) begin
                        state_d = StExtBrk;
                    end else if (scan_data != 8'hE0) begin
                        emit    = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = StIdle;
                    end
                end
                StBrk: begin
                    emit    = 1'b1;
                    ev_brk  = 1'b1;
                    state_d = StIdle;
                end
                StExtBrk: begin
                    emit    = 1'b1;
                    ev_brk  = 1'b1;
                    ev_ext  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign ev_key   = {ev_ext, scan_data};
    assign held_hit = held_valid_q && (ev_key == held_q);

    // Held-key tracking; held follows makes even when makes are not reported
    always_comb begin
        held_valid_d = held_valid_q;
        held_d       = held_q;
        wr_en        = 1'b0;
        if (emit) begin
            if (ev_brk) begin
                wr_en = 1'b1;
                if (held_hit) begin
                    held_valid_d = 1'b0;
                end
            end else if (!(held_hit && FILTER_REPEAT)) begin
                wr_en        = REPORT_MAKE;
                held_valid_d = 1'b1;
                held_d       = ev_key;
            end
        end
    end

    assign kb_buf_empty = (count_q == '0);
    assign kb_buf_full  = (count_q == CountFull);
    assign do_pop       = rd_key_event && !kb_buf_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write
    assign do_push      = wr_en && (!kb_buf_full || rd_key_event);
    assign drop         = wr_en && kb_buf_full && !rd_key_event;

    always_comb begin
        wr_ptr_d   = do_push ? wr_ptr_q + W_SIZE'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop ? rd_ptr_q + W_SIZE'(1) : rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (W_SIZE + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (W_SIZE + 1)'(1);
        end
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            held_valid_q <= 1'b0;
            held_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_valid_q <= held_valid_d;
            held_q       <= held_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {ev_brk, ev_key};
        end
    end

    assign key_event = mem_q[rd_ptr_q];
    assign overflow  = overflow_q;

endmodule
